// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-road traffic light sequencer.
// Optional build macro used by the top level: FLASH_RED_EN.
package traffic_pkg;

    localparam int unsigned CNT_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        S_ALL_RED = 3'd0,
        S_A_YUP   = 3'd1,
        S_A_GRN   = 3'd2,
        S_A_YDN   = 3'd3,
        S_B_YUP   = 3'd4,
        S_B_GRN   = 3'd5,
        S_B_YDN   = 3'd6
    } state_t;

    // One-hot lamp encoding per road: {green, yellow, red}
    localparam logic [2:0] LAMP_RED    = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b100;

    // Successor in the running cycle; ALL_RED only ever leads into road A
    function automatic state_t next_phase(input state_t s);
        case (s)
            S_ALL_RED: next_phase = S_A_YUP;
            S_A_YUP:   next_phase = S_A_GRN;
            S_A_GRN:   next_phase = S_A_YDN;
            S_A_YDN:   next_phase = S_B_YUP;
            S_B_YUP:   next_phase = S_B_GRN;
            S_B_GRN:   next_phase = S_B_YDN;
            S_B_YDN:   next_phase = S_A_YUP;
            default:   next_phase = S_ALL_RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_controller_if.sv
// Pad-side signal bundle of the traffic light controller.
// The master side drives the run request; the slave side (the controller) drives lamps and debug phase.
interface traffic_light_controller_if;

    logic       enable;
    logic [2:0] light_a;
    logic [2:0] light_b;
    logic [2:0] phase;

    modport master (
        output enable,
        input  light_a,
        input  light_b,
        input  phase
    );

    modport slave (
        input  enable,
        output light_a,
        output light_b,
        output phase
    );

endinterface

// File: rtl/traffic_light_controller_phase_timer.sv
// Down-counting phase timer: load has priority, otherwise counts down while en is high.
// done flags a count of zero; the count saturates there until reloaded.
module phase_timer
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W     = CNT_W_DEFAULT,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [CNT_W-1:0] r_count;

    // Count register: reload on phase entry, decrement otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= CNT_W'(RESET_VAL);
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign done = (r_count == '0);

endmodule

// File: rtl/traffic_light_controller.sv
// Two-road traffic light sequencer: enable synchroniser, phase FSM and lamp decode.
// Build macro FLASH_RED_EN: while disabled, both roads blink red every FLASH_TICKS cycles.
module traffic_light_controller
    import traffic_pkg::*;
#(
    parameter int unsigned ALL_RED_TICKS = 100,
    parameter int unsigned YELLOW_TICKS  = 200,
    parameter int unsigned GREEN_TICKS   = 1000,
    parameter int unsigned CNT_W         = CNT_W_DEFAULT
`ifdef FLASH_RED_EN
    ,
    parameter int unsigned FLASH_TICKS   = 50
`endif
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    traffic_light_controller_if.slave   bus
);

    logic             r_en_meta;
    logic             r_en_s;
    state_t           r_state;
    state_t           w_next_state;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_done;
    logic             w_lamps_on;
    logic [2:0]       w_light_a;
    logic [2:0]       w_light_b;

    // Phase length minus one for the state being entered
    function automatic logic [CNT_W-1:0] dur_m1(input state_t s);
        case (s)
            S_A_YUP, S_A_YDN, S_B_YUP, S_B_YDN: dur_m1 = CNT_W'(YELLOW_TICKS - 1);
            S_A_GRN, S_B_GRN:                   dur_m1 = CNT_W'(GREEN_TICKS - 1);
            default:                            dur_m1 = CNT_W'(ALL_RED_TICKS - 1);
        endcase
    endfunction

    // Two-flop synchroniser for the asynchronous pad enable
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_en_meta <= 1'b0;
            r_en_s    <= 1'b0;
        end else begin
            r_en_meta <= bus.enable;
            r_en_s    <= r_en_meta;
        end
    end

    // State register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= S_ALL_RED;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and timer reload; disable overrides any timer expiry
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_val   = CNT_W'(ALL_RED_TICKS - 1);
        if (!r_en_s) begin
            w_next_state = S_ALL_RED;
            w_load       = 1'b1;
        end else begin
            case (r_state)
                S_ALL_RED, S_A_YUP, S_A_GRN, S_A_YDN, S_B_YUP, S_B_GRN, S_B_YDN: begin
                    if (w_done) begin
                        w_next_state = next_phase(r_state);
                        w_load       = 1'b1;
                        w_load_val   = dur_m1(next_phase(r_state));
                    end
                end
                default: begin
                    w_next_state = S_ALL_RED;
                    w_load       = 1'b1;
                end
            endcase
        end
    end

    phase_timer #(
        .CNT_W     (CNT_W),
        .RESET_VAL (ALL_RED_TICKS - 1)
    ) u_phase_timer (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .load     (w_load),
        .load_val (w_load_val),
        .en       (r_en_s),
        .done     (w_done)
    );

`ifdef FLASH_RED_EN
    logic [CNT_W-1:0] r_flash_cnt;
    logic             r_lit;
    logic             w_flashing;

    // Blink only once the FSM actually sits in ALL_RED with the road disabled,
    // so the first blink period starts lit on the cycle the abort lands.
    assign w_flashing = !r_en_s && (r_state == S_ALL_RED);

    // Blink phase counter and lamp-lit flag
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_flash_cnt <= '0;
            r_lit       <= 1'b1;
        end else if (!w_flashing) begin
            r_flash_cnt <= '0;
            r_lit       <= 1'b1;
        end else if (r_flash_cnt == CNT_W'(FLASH_TICKS - 1)) begin
            r_flash_cnt <= '0;
            r_lit       <= ~r_lit;
        end else begin
            r_flash_cnt <= r_flash_cnt + CNT_W'(1);
        end
    end

    // Enabled operation always shows lamps, including the first re-enabled cycle
    assign w_lamps_on = r_lit | r_en_s;
`else
    assign w_lamps_on = 1'b1;
`endif

    // Lamp decode from the state register
    always_comb begin
        w_light_a = LAMP_RED;
        w_light_b = LAMP_RED;
        case (r_state)
            S_A_YUP, S_A_YDN: w_light_a = LAMP_YELLOW;
            S_A_GRN:          w_light_a = LAMP_GREEN;
            S_B_YUP, S_B_YDN: w_light_b = LAMP_YELLOW;
            S_B_GRN:          w_light_b = LAMP_GREEN;
            default: ;
        endcase
        if (!w_lamps_on) begin
            w_light_a = '0;
            w_light_b = '0;
        end
    end

    assign bus.light_a = w_light_a;
    assign bus.light_b = w_light_b;
    assign bus.phase   = r_state;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed testbench for traffic_light_controller with ALL_RED=4, YELLOW=3, GREEN=5 ticks.
// Build macro FLASH_RED_EN selects the blinking-red expectations (FLASH_TICKS=2).
module tb_traffic_light_controller;

    localparam logic [5:0] RR  = 6'b001_001;
    localparam logic [5:0] AY  = 6'b010_001;
    localparam logic [5:0] AG  = 6'b100_001;
    localparam logic [5:0] BY  = 6'b001_010;
    localparam logic [5:0] BG  = 6'b001_100;
    localparam logic [5:0] OFF = 6'b000_000;
`ifdef FLASH_RED_EN
    localparam bit FLASH_BUILD = 1'b1;
`else
    localparam bit FLASH_BUILD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_vec  = 0;
    int   n_miss = 0;

    traffic_light_controller_if bus ();

    always #5 clk = ~clk;

    traffic_light_controller #(
        .ALL_RED_TICKS (4),
        .YELLOW_TICKS  (3),
        .GREEN_TICKS   (5)
`ifdef FLASH_RED_EN
        ,
        .FLASH_TICKS   (2)
`endif
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    task automatic chk_vec(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic sample(input string tag, input logic [5:0] exp_lamps, input logic [2:0] exp_phase);
        logic [2:0] la;
        logic [2:0] lb;
        logic       safe;
        la = bus.light_a;
        lb = bus.light_b;
        chk_vec({tag, "/lamps"}, {2'b00, la, lb}, {2'b00, exp_lamps});
        chk_vec({tag, "/phase"}, {5'b0, bus.phase}, {5'b0, exp_phase});
        if (exp_lamps != OFF) begin
            safe = $onehot(la) && $onehot(lb) && ((la == 3'b001) || (lb == 3'b001));
            chk_vec({tag, "/safe"}, {7'b0, safe}, 8'h01);
        end
    endtask

    task automatic expect_seg(input string tag, input logic [5:0] lamps, input logic [2:0] ph, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample(tag, lamps, ph);
        end
    endtask

    task automatic run_period(input string tag);
        expect_seg({tag, "/a_yup"}, AY, 3'd1, 3);
        expect_seg({tag, "/a_grn"}, AG, 3'd2, 5);
        expect_seg({tag, "/a_ydn"}, AY, 3'd3, 3);
        expect_seg({tag, "/b_yup"}, BY, 3'd4, 3);
        expect_seg({tag, "/b_grn"}, BG, 3'd5, 5);
        expect_seg({tag, "/b_ydn"}, BY, 3'd6, 3);
    endtask

    initial begin
        // Reset held with the pad asking to run
        rst        = 1'b1;
        bus.enable = 1'b1;
        expect_seg("in_reset", RR, 3'd0, 3);

        // Released but disabled: steady red (or blinking red in the flash build)
        bus.enable = 1'b0;
        rst        = 1'b0;
        for (int k = 1; k <= 52; k++) begin
            @(negedge clk);
            sample("idle", (FLASH_BUILD && ((k / 2) % 2 == 1)) ? OFF : RR, 3'd0);
        end

        // Enable: 2 sync edges + 4 ALL_RED cycles, then three full 22-cycle periods
        bus.enable = 1'b1;
        expect_seg("startup_red", RR, 3'd0, 5);
        run_period("cyc1");
        run_period("cyc2");
        run_period("cyc3");

        // Abort during A green, then re-enable
        expect_seg("cyc4/a_yup", AY, 3'd1, 3);
        expect_seg("cyc4/a_grn", AG, 3'd2, 2);
        bus.enable = 1'b0;
        expect_seg("abort_sync", AG, 3'd2, 2);
        expect_seg("abort_red", RR, 3'd0, 2);
        expect_seg("abort_red2", FLASH_BUILD ? OFF : RR, 3'd0, 2);
        bus.enable = 1'b1;
        expect_seg("reen_red", RR, 3'd0, 5);
        run_period("cyc5");
        expect_seg("cyc6/a_yup", AY, 3'd1, 3);
        expect_seg("cyc6/a_grn", AG, 3'd2, 5);
        expect_seg("cyc6/a_ydn", AY, 3'd3, 3);
        expect_seg("cyc6/b_yup", BY, 3'd4, 3);
        expect_seg("cyc6/b_grn", BG, 3'd5, 2);

        // Asynchronous reset between clock edges during B green
        #2;
        rst = 1'b1;
        #1;
        sample("async_rst", RR, 3'd0);
        @(negedge clk);
        sample("rst_hold", RR, 3'd0);
        rst = 1'b0;
        expect_seg("post_rst_red", RR, 3'd0, 5);
        expect_seg("post_rst/a_yup", AY, 3'd1, 3);
        expect_seg("post_rst/a_grn", AG, 3'd2, 1);

`ifdef FLASH_RED_EN
        // Blink while disabled, then lit all-red on re-enable
        bus.enable = 1'b0;
        expect_seg("flash_sync", AG, 3'd2, 2);
        expect_seg("flash_on1", RR, 3'd0, 2);
        expect_seg("flash_off", OFF, 3'd0, 2);
        expect_seg("flash_on2", RR, 3'd0, 2);
        bus.enable = 1'b1;
        expect_seg("flash_last_off", OFF, 3'd0, 1);
        expect_seg("flash_reen_red", RR, 3'd0, 4);
        expect_seg("flash_reen_ay", AY, 3'd1, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
